lcd_ctrl_gen: RTL and testbench

//  Parametrised successor of the 8x8 LCD image controller: NxN image, DW-bit pixels.

---
 rtl/lcd_ctrl_pkg.sv | 29 ++
 rtl/lcd_ctrl_gen_win_alu.sv | 52 +++++
 rtl/lcd_ctrl_gen.sv | 159 +++++++++++++++
 tb/tb_lcd_ctrl_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller states for the NxN LCD image controller.
package lcd_ctrl_pkg;

  typedef logic [3:0] cmd_t;

  localparam cmd_t CMD_WRITE  = 4'h0;
  localparam cmd_t CMD_UP     = 4'h1;
  localparam cmd_t CMD_DOWN   = 4'h2;
  localparam cmd_t CMD_LEFT   = 4'h3;
  localparam cmd_t CMD_RIGHT  = 4'h4;
  localparam cmd_t CMD_MAX    = 4'h5;
  localparam cmd_t CMD_MIN    = 4'h6;
  localparam cmd_t CMD_AVG    = 4'h7;
  localparam cmd_t CMD_CCW    = 4'h8;
  localparam cmd_t CMD_CW     = 4'h9;
  localparam cmd_t CMD_MIRX   = 4'hA;
  localparam cmd_t CMD_MIRY   = 4'hB;
  localparam cmd_t CMD_CENTRE = 4'hC;
  localparam cmd_t CMD_INV    = 4'hD;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_IDLE,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/lcd_ctrl_gen_win_alu.sv
// Combinational 2x2 window operator: a b / c d in, rewritten window out.
// Codes with no pixel effect (write, shifts, centre, reserved) pass the window through.
module lcd_win_alu
  import lcd_ctrl_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  input  logic [DW-1:0] d_i,
  input  cmd_t          op_i,
  output logic [DW-1:0] a_o,
  output logic [DW-1:0] b_o,
  output logic [DW-1:0] c_o,
  output logic [DW-1:0] d_o
);

  logic [DW-1:0] max_ab, max_cd, max_all;
  logic [DW-1:0] min_ab, min_cd, min_all;
  logic [DW+1:0] sum;
  logic [DW-1:0] avg;

  assign max_ab  = (a_i > b_i) ? a_i : b_i;
  assign max_cd  = (c_i > d_i) ? c_i : d_i;
  assign max_all = (max_ab > max_cd) ? max_ab : max_cd;
  assign min_ab  = (a_i < b_i) ? a_i : b_i;
  assign min_cd  = (c_i < d_i) ? c_i : d_i;
  assign min_all = (min_ab < min_cd) ? min_ab : min_cd;
  // Two guard bits keep the four-way sum exact before the divide by 4.
  assign sum = {2'b00, a_i} + {2'b00, b_i} + {2'b00, c_i} + {2'b00, d_i};
  assign avg = DW'(sum >> 2);

  always_comb begin
    a_o = a_i;
    b_o = b_i;
    c_o = c_i;
    d_o = d_i;
    case (op_i)
      CMD_MAX: begin a_o = max_all; b_o = max_all; c_o = max_all; d_o = max_all; end
      CMD_MIN: begin a_o = min_all; b_o = min_all; c_o = min_all; d_o = min_all; end
      CMD_AVG: begin a_o = avg;     b_o = avg;     c_o = avg;     d_o = avg;     end
      CMD_CCW: begin a_o = b_i;     b_o = d_i;     c_o = a_i;     d_o = c_i;     end
      CMD_CW:  begin a_o = c_i;     b_o = a_i;     c_o = d_i;     d_o = b_i;     end
      CMD_MIRX: begin a_o = c_i;    b_o = d_i;     c_o = a_i;     d_o = b_i;     end
      CMD_MIRY: begin a_o = b_i;    b_o = a_i;     c_o = d_i;     d_o = c_i;     end
      CMD_INV: begin a_o = ~a_i;    b_o = ~b_i;    c_o = ~c_i;    d_o = ~d_i;    end
      default: ;
    endcase
  end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// NxN LCD image controller: loads the image from IROM, applies 2x2 window commands
// around an operation point, and streams the buffer to IRAM on WRITE.
module lcd_ctrl_gen
  import lcd_ctrl_pkg::*;
#(
  parameter int  IMG_N = 8,
  parameter int  DW    = 8,
  localparam int AW    = 2*$clog2(IMG_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    cmd,
  input  logic          cmd_valid,
  output logic          IROM_rd,
  output logic [AW-1:0] IROM_A,
  input  logic [DW-1:0] IROM_Q,
  output logic          IRAM_valid,
  output logic [DW-1:0] IRAM_D,
  output logic [AW-1:0] IRAM_A,
  output logic          busy,
  output logic          done
);

  localparam int              PW        = $clog2(IMG_N);
  localparam int              NPIX      = IMG_N*IMG_N;
  localparam logic [AW-1:0]   ADDR_LAST = AW'(NPIX-1);
  localparam logic [PW-1:0]   PT_CTR    = PW'(IMG_N/2);
  localparam logic [PW-1:0]   PT_MIN    = PW'(1);
  localparam logic [PW-1:0]   PT_MAX    = PW'(IMG_N-1);

  state_t        state_q;
  cmd_t          cmd_q;
  logic [PW-1:0] x_q, y_q;
  logic [AW-1:0] cnt_q;
  logic          rd_q, ram_vld_q, busy_q, done_q;
  logic [DW-1:0] ram_d_q;
  logic [DW-1:0] pix_q [NPIX];

  logic [PW-1:0] xm1, ym1;
  logic [AW-1:0] ia, ib, ic, id, cnt_inc;
  logic [DW-1:0] na, nb, nc, nd;

  // IMG_N is a power of two, so {row, col} is exactly row*IMG_N+col.
  assign xm1     = x_q - PT_MIN;
  assign ym1     = y_q - PT_MIN;
  assign ia      = {ym1, xm1};
  assign ib      = {ym1, x_q};
  assign ic      = {y_q, xm1};
  assign id      = {y_q, x_q};
  assign cnt_inc = cnt_q + AW'(1);

  lcd_win_alu #(.DW(DW)) u_win_alu (
    .a_i  (pix_q[ia]),
    .b_i  (pix_q[ib]),
    .c_i  (pix_q[ic]),
    .d_i  (pix_q[id]),
    .op_i (cmd_q),
    .a_o  (na),
    .b_o  (nb),
    .c_o  (nc),
    .d_o  (nd)
  );

  // ROM data for the address driven last cycle lands while rd is still high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_q == ST_LOAD && rd_q) begin
        pix_q[cnt_q] <= IROM_Q;
      end else if (state_q == ST_EXEC) begin
        pix_q[ia] <= na;
        pix_q[ib] <= nb;
        pix_q[ic] <= nc;
        pix_q[id] <= nd;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_LOAD;
      cmd_q     <= CMD_WRITE;
      x_q       <= PT_CTR;
      y_q       <= PT_CTR;
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      ram_vld_q <= 1'b0;
      ram_d_q   <= '0;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (rd_q) begin
            if (cnt_q == ADDR_LAST) rd_q <= 1'b0;
            else                    cnt_q <= cnt_inc;
          end else if (cnt_q == ADDR_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            rd_q <= 1'b1;
          end
        end
        ST_IDLE: begin
          if (cmd_valid && !busy_q) begin
            busy_q <= 1'b1;
            cmd_q  <= cmd;
            if (cmd == CMD_WRITE) begin
              state_q   <= ST_WRITE;
              ram_vld_q <= 1'b1;
              cnt_q     <= '0;
              ram_d_q   <= pix_q[0];
            end else begin
              state_q <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          case (cmd_q)
            CMD_UP:     if (y_q != PT_MIN) y_q <= y_q - PT_MIN;
            CMD_DOWN:   if (y_q != PT_MAX) y_q <= y_q + PT_MIN;
            CMD_LEFT:   if (x_q != PT_MIN) x_q <= x_q - PT_MIN;
            CMD_RIGHT:  if (x_q != PT_MAX) x_q <= x_q + PT_MIN;
            CMD_CENTRE: begin x_q <= PT_CTR; y_q <= PT_CTR; end
            default: ;
          endcase
        end
        ST_WRITE: begin
          if (cnt_q == ADDR_LAST) begin
            ram_vld_q <= 1'b0;
            done_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ST_DONE;
          end else begin
            cnt_q   <= cnt_inc;
            ram_d_q <= pix_q[cnt_inc];
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  assign IROM_rd    = rd_q;
  assign IROM_A     = cnt_q;
  assign IRAM_valid = ram_vld_q;
  assign IRAM_D     = ram_d_q;
  assign IRAM_A     = cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Bench: directed 8x8 table with ramp image, reset mid-WRITE, and a random
// 16x16/10-bit command stream checked against an array-based image model.
module tb_lcd_ctrl_gen;

  localparam int NA  = 8;
  localparam int DA  = 8;
  localparam int AWA = 6;
  localparam int PA  = NA*NA;
  localparam int NB  = 16;
  localparam int DB  = 10;
  localparam int AWB = 8;
  localparam int PB  = NB*NB;
  localparam int LIM = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_a, cmd_valid_a, IROM_rd_a, IRAM_valid_a, busy_a, done_a;
  logic [3:0]     cmd_a;
  logic [AWA-1:0] IROM_A_a, IRAM_A_a;
  logic [DA-1:0]  IROM_Q_a, IRAM_D_a;
  logic           reset_b, cmd_valid_b, IROM_rd_b, IRAM_valid_b, busy_b, done_b;
  logic [3:0]     cmd_b;
  logic [AWB-1:0] IROM_A_b, IRAM_A_b;
  logic [DB-1:0]  IROM_Q_b, IRAM_D_b;

  lcd_ctrl_gen #(.IMG_N(NA), .DW(DA)) u_dut_a (
    .clk(clk), .reset(reset_a), .cmd(cmd_a), .cmd_valid(cmd_valid_a),
    .IROM_rd(IROM_rd_a), .IROM_A(IROM_A_a), .IROM_Q(IROM_Q_a),
    .IRAM_valid(IRAM_valid_a), .IRAM_D(IRAM_D_a), .IRAM_A(IRAM_A_a),
    .busy(busy_a), .done(done_a)
  );

  lcd_ctrl_gen #(.IMG_N(NB), .DW(DB)) u_dut_b (
    .clk(clk), .reset(reset_b), .cmd(cmd_b), .cmd_valid(cmd_valid_b),
    .IROM_rd(IROM_rd_b), .IROM_A(IROM_A_b), .IROM_Q(IROM_Q_b),
    .IRAM_valid(IRAM_valid_b), .IRAM_D(IRAM_D_b), .IRAM_A(IRAM_A_b),
    .busy(busy_b), .done(done_b)
  );

  logic [DA-1:0] rom_a [PA];
  logic [DA-1:0] ram_a [PA];
  logic [DB-1:0] rom_b [PB];
  logic [DB-1:0] ram_b [PB];
  int wr_a = 0, wr_b = 0, dn_a = 0, dn_b = 0;
  int checks = 0, failures = 0;
  int mb [PB];
  int px, py;

  // ROM answers one edge after the address; RAM samples on the falling edge.
  always @(negedge clk) begin
    IROM_Q_a = rom_a[IROM_A_a];
    IROM_Q_b = rom_b[IROM_A_b];
    if (IRAM_valid_a) begin ram_a[IRAM_A_a] = IRAM_D_a; wr_a++; end
    if (IRAM_valid_b) begin ram_b[IRAM_A_b] = IRAM_D_b; wr_b++; end
    if (done_a) dn_a++;
    if (done_b) dn_b++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset(input bit sel, output int ncyc);
    int n;
    if (sel) reset_b = 1'b1; else reset_a = 1'b1;
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    repeat (2) @(negedge clk);
    if (!sel)
      chk("reset_vals",
          32'({IROM_rd_a, IROM_A_a, IRAM_valid_a, IRAM_D_a, IRAM_A_a, busy_a, done_a}),
          32'({1'b0, 6'd0, 1'b0, 8'd0, 6'd0, 1'b1, 1'b0}));
    if (sel) reset_b = 1'b0; else reset_a = 1'b0;
    n = 0;
    while ((sel ? busy_b : busy_a) && n < LIM) begin n++; @(negedge clk); end
    chk("load_finishes", 32'(n < LIM), 1);
    ncyc = n;
  endtask

  task automatic issue(input bit sel, input logic [3:0] c);
    int n;
    if (sel) begin cmd_b = c; cmd_valid_b = 1'b1; end
    else     begin cmd_a = c; cmd_valid_a = 1'b1; end
    @(negedge clk);
    cmd_valid_a = 1'b0;
    cmd_valid_b = 1'b0;
    chk("busy_on_accept", 32'(sel ? busy_b : busy_a), 1);
    // A command offered while busy must be dropped, not queued.
    if (sel && $urandom_range(0, 2) == 0) begin
      cmd_b = 4'($urandom_range(0, 15));
      cmd_valid_b = 1'b1;
      @(negedge clk);
      cmd_valid_b = 1'b0;
    end
    n = 0;
    while ((sel ? busy_b : busy_a) && n < LIM) begin @(negedge clk); n++; end
    chk("cmd_completes", 32'(n < LIM), 1);
  endtask

  task automatic model_apply(input int c);
    int idx[4];
    int p[4];
    int q[4];
    int v;
    idx[0] = (py-1)*NB + (px-1);
    idx[1] = idx[0] + 1;
    idx[2] = idx[0] + NB;
    idx[3] = idx[0] + NB + 1;
    for (int k = 0; k < 4; k++) begin p[k] = mb[idx[k]]; q[k] = p[k]; end
    case (c)
      1: if (py > 1)    py--;
      2: if (py < NB-1) py++;
      3: if (px > 1)    px--;
      4: if (px < NB-1) px++;
      5: begin v = p[0]; for (int k = 1; k < 4; k++) if (p[k] > v) v = p[k];
           for (int k = 0; k < 4; k++) q[k] = v; end
      6: begin v = p[0]; for (int k = 1; k < 4; k++) if (p[k] < v) v = p[k];
           for (int k = 0; k < 4; k++) q[k] = v; end
      7: begin v = (p[0] + p[1] + p[2] + p[3]) / 4;
           for (int k = 0; k < 4; k++) q[k] = v; end
      8:  begin q[0] = p[1]; q[1] = p[3]; q[3] = p[2]; q[2] = p[0]; end
      9:  begin q[0] = p[2]; q[2] = p[3]; q[3] = p[1]; q[1] = p[0]; end
      10: begin q[0] = p[2]; q[2] = p[0]; q[1] = p[3]; q[3] = p[1]; end
      11: begin q[0] = p[1]; q[1] = p[0]; q[2] = p[3]; q[3] = p[2]; end
      12: begin px = NB/2; py = NB/2; end
      13: for (int k = 0; k < 4; k++) q[k] = (1 << DB) - 1 - p[k];
      default: ;
    endcase
    for (int k = 0; k < 4; k++) mb[idx[k]] = q[k];
  endtask

  typedef struct packed {
    logic [2:0]  ncmd;
    logic [23:0] cmds;   // nibble j = j-th command
    logic [5:0]  idx0;   // index of window pixel a
    logic [31:0] exp;    // byte j = expected a,b,c,d
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin : main
    int n, w0, d0, mism, base, c;
    int widx[4];
    bit in_win;

    reset_a = 1'b1; reset_b = 1'b1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_a = '0; cmd_b = '0;
    for (int k = 0; k < PA; k++) rom_a[k] = DA'(k);
    for (int k = 0; k < PB; k++) rom_b[k] = DB'($urandom_range(0, (1 << DB) - 1));

    vec[0] = '{ncmd: 3'd1, cmds: 24'h000005, idx0: 6'd27, exp: 32'h24242424};
    vec[1] = '{ncmd: 3'd6, cmds: 24'h733333, idx0: 6'd24, exp: 32'h1C1C1C1C};
    vec[2] = '{ncmd: 3'd2, cmds: 24'h0000B9, idx0: 6'd27, exp: 32'h241C231B};
    vec[3] = '{ncmd: 3'd1, cmds: 24'h00000D, idx0: 6'd27, exp: 32'hDBDCE3E4};
    vec[4] = '{ncmd: 3'd4, cmds: 24'h00DC4D, idx0: 6'd27, exp: 32'h24231C1B};
    vec[5] = '{ncmd: 3'd2, cmds: 24'h000061, idx0: 6'd19, exp: 32'h13131313};
    vec[6] = '{ncmd: 3'd1, cmds: 24'h000008, idx0: 6'd27, exp: 32'h231B241C};
    vec[7] = '{ncmd: 3'd1, cmds: 24'h00000A, idx0: 6'd27, exp: 32'h1C1B2423};
    vec[8] = '{ncmd: 3'd3, cmds: 24'h0002FE, idx0: 6'd35, exp: 32'h2C2B2423};
    vec[9] = '{ncmd: 3'd6, cmds: 24'h544444, idx0: 6'd30, exp: 32'h27272727};

    // Load timing and immediate WRITE of the ramp image.
    do_reset(0, n);
    chk("load_busy_cycles", 32'(n), 66);
    w0 = wr_a; d0 = dn_a;
    issue(0, 4'h0);
    mism = 0;
    for (int k = 0; k < PA; k++) if (ram_a[k] !== DA'(k)) mism++;
    chk("ramp_write_data", 32'(mism), 0);
    chk("ramp_write_cnt", 32'(wr_a - w0), PA);
    chk("ramp_done_once", 32'(dn_a - d0), 1);

    for (int r = 0; r < NV; r++) begin
      do_reset(0, n);
      for (int j = 0; j < int'(vec[r].ncmd); j++) issue(0, vec[r].cmds[4*j +: 4]);
      for (int k = 0; k < PA; k++) ram_a[k] = 'x;
      w0 = wr_a; d0 = dn_a;
      issue(0, 4'h0);
      chk($sformatf("row%0d_wr_cnt", r), 32'(wr_a - w0), PA);
      chk($sformatf("row%0d_done", r), 32'(dn_a - d0), 1);
      base = int'(vec[r].idx0);
      widx[0] = base; widx[1] = base + 1; widx[2] = base + NA; widx[3] = base + NA + 1;
      for (int j = 0; j < 4; j++)
        chk($sformatf("row%0d_win%0d", r, j), 32'(ram_a[widx[j]]), 32'(vec[r].exp[8*j +: 8]));
      mism = 0;
      for (int k = 0; k < PA; k++) begin
        in_win = (k == widx[0]) || (k == widx[1]) || (k == widx[2]) || (k == widx[3]);
        if (!in_win && ram_a[k] !== DA'(k)) mism++;
      end
      chk($sformatf("row%0d_others", r), 32'(mism), 0);
    end

    // Reset in the middle of a WRITE burst.
    do_reset(0, n);
    d0 = dn_a;
    cmd_a = 4'h0; cmd_valid_a = 1'b1;
    @(negedge clk);
    cmd_valid_a = 1'b0;
    n = 0;
    while (!(IRAM_valid_a && IRAM_A_a == AWA'(20)) && n < 200) begin @(negedge clk); n++; end
    chk("midwr_reach_k20", 32'(n < 200), 1);
    reset_a = 1'b1;
    @(negedge clk);
    chk("midwr_valid_low", 32'(IRAM_valid_a), 0);
    reset_a = 1'b0;
    @(negedge clk);
    chk("midwr_load_restart", 32'({IROM_rd_a, IROM_A_a}), 32'({1'b1, 6'd0}));
    n = 0;
    while (busy_a && n < LIM) begin @(negedge clk); n++; end
    chk("midwr_reload_done", 32'(n < LIM), 1);
    chk("midwr_no_done", 32'(dn_a - d0), 0);
    w0 = wr_a;
    issue(0, 4'h0);
    mism = 0;
    for (int k = 0; k < PA; k++) if (ram_a[k] !== DA'(k)) mism++;
    chk("midwr_reloaded_image", 32'(mism), 0);
    chk("midwr_write_cnt", 32'(wr_a - w0), PA);

    // Random command stream on the 16x16, 10-bit instance.
    do_reset(1, n);
    for (int k = 0; k < PB; k++) mb[k] = int'(rom_b[k]);
    px = NB/2; py = NB/2;
    for (int t = 0; t < 250; t++) begin
      c = int'($urandom_range(0, 15));
      if ($urandom_range(0, 11) == 0) c = 0;
      if (t >= 60 && t < 76)   c = 3;
      if (t >= 150 && t < 166) c = 2;
      if (t == 249) c = 0;
      if (c == 0) begin
        for (int k = 0; k < PB; k++) ram_b[k] = 'x;
        w0 = wr_b; d0 = dn_b;
        issue(1, 4'h0);
        mism = 0;
        for (int k = 0; k < PB; k++) if (ram_b[k] !== DB'(mb[k])) mism++;
        chk($sformatf("rand_t%0d_data", t), 32'(mism), 0);
        chk($sformatf("rand_t%0d_cnt", t), 32'(wr_b - w0), PB);
        chk($sformatf("rand_t%0d_done", t), 32'(dn_b - d0), 1);
      end else begin
        issue(1, 4'(c));
        model_apply(c);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
